// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, multiplier latency and a
// width-generic saturating adder for signed accumulators.
package alu_pkg;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    localparam int MUL_LAT = 1;
    localparam int SAT_W   = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] sum;
        logic                    sat;
    } sat_result_t;

    function automatic logic signed [SAT_W-1:0] sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

    // Operands are sign-extended to SAT_W so the raw sum never wraps for any acc_w < SAT_W.
    function automatic sat_result_t sat_add(input logic signed [SAT_W-1:0] a,
                                            input logic signed [SAT_W-1:0] b,
                                            input int                      acc_w);
        logic signed [SAT_W-1:0] raw;
        sat_result_t             res;
        raw     = a + b;
        res.sum = raw;
        res.sat = 1'b0;
        if (raw > sat_max(acc_w)) begin
            res.sum = sat_max(acc_w);
            res.sat = 1'b1;
        end else if (raw < sat_min(acc_w)) begin
            res.sum = sat_min(acc_w);
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Job control, operand stream, multiplier link and result port of the MAC sequencer.
interface mac_sequencer_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 4
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [7:0]       in_x;
    logic signed [7:0]       in_y;
    logic signed [7:0]       mul_x;
    logic signed [7:0]       mul_y;
    logic signed [15:0]      mul_z;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_acc;
    logic                    out_sat;

    modport master (
        output start, len, in_valid, in_x, in_y, mul_z, out_ready,
        input  busy, in_ready, mul_x, mul_y, out_valid, out_acc, out_sat
    );

    modport slave (
        input  start, len, in_valid, in_x, in_y, mul_z, out_ready,
        output busy, in_ready, mul_x, mul_y, out_valid, out_acc, out_sat
    );
endinterface

// File: rtl/mac_sequencer.sv
// Feeds signed operand pairs to an external registered multiplier and
// accumulates the returning products with saturation.
module mac_sequencer
    import alu_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int LEN_W = 4
) (
    input  logic            cclk,
    input  logic            rst,
    mac_sequencer_if.slave  bus
);

    state_t                  state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic                    sat_reg, sat_next;
    logic [LEN_W-1:0]        remaining_reg, remaining_next;
    logic signed [7:0]       mul_x_reg, mul_y_reg;
    // Bit 0 marks a pair issued to the multiplier (p1); bit MUL_LAT marks its product arriving (p2).
    logic [MUL_LAT:0]        pipe_reg;
    logic                    accept;
    logic                    clear;
    sat_result_t             add_res;
    logic                    sum_unused;

    assign accept = bus.in_valid && (state_reg == FEED);

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        clear          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    clear = 1'b1;
                    if (bus.len != '0) begin
                        state_next     = FEED;
                        remaining_next = bus.len;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            FEED: begin
                if (accept) begin
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == LEN_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_reg[MUL_LAT] && !(|pipe_reg[MUL_LAT-1:0])) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        add_res  = sat_add(SAT_W'(acc_reg), SAT_W'(bus.mul_z), ACC_W);
        acc_next = acc_reg;
        sat_next = sat_reg;
        if (clear) begin
            acc_next = '0;
            sat_next = 1'b0;
        end else if (pipe_reg[MUL_LAT]) begin
            acc_next = add_res.sum[ACC_W-1:0];
            sat_next = sat_reg | add_res.sat;
        end
    end

    assign sum_unused = ^add_res.sum[SAT_W-1:ACC_W];

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            sat_reg       <= 1'b0;
            remaining_reg <= '0;
            mul_x_reg     <= '0;
            mul_y_reg     <= '0;
            pipe_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            sat_reg       <= sat_next;
            remaining_reg <= remaining_next;
            pipe_reg      <= {pipe_reg[MUL_LAT-1:0], accept};
            if (accept) begin
                mul_x_reg <= bus.in_x;
                mul_y_reg <= bus.in_y;
            end
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.in_ready  = (state_reg == FEED);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_acc   = acc_reg;
    assign bus.out_sat   = sat_reg;
    assign bus.mul_x     = mul_x_reg;
    assign bus.mul_y     = mul_y_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench: drives one stimulus stream into a 24-bit and a 16-bit
// accumulator instance and checks each result against hand-computed values.
module tb_mac_sequencer;

    localparam int LEN_W = 4;

    logic cclk = 1'b0;
    logic rst  = 1'b0;
    always #5 cclk = ~cclk;

    logic                    start = 1'b0;
    logic [LEN_W-1:0]        len = '0;
    logic                    in_valid = 1'b0;
    logic signed [7:0]       in_x = '0;
    logic signed [7:0]       in_y = '0;
    logic                    out_ready = 1'b0;

    mac_sequencer_if #(.ACC_W(24), .LEN_W(LEN_W)) bus_a ();
    mac_sequencer_if #(.ACC_W(16), .LEN_W(LEN_W)) bus_b ();

    mac_sequencer #(.ACC_W(24), .LEN_W(LEN_W)) dut_a (.cclk(cclk), .rst(rst), .bus(bus_a.slave));
    mac_sequencer #(.ACC_W(16), .LEN_W(LEN_W)) dut_b (.cclk(cclk), .rst(rst), .bus(bus_b.slave));

    assign bus_a.start = start;     assign bus_b.start = start;
    assign bus_a.len = len;         assign bus_b.len = len;
    assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid;
    assign bus_a.in_x = in_x;       assign bus_b.in_x = in_x;
    assign bus_a.in_y = in_y;       assign bus_b.in_y = in_y;
    assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;

    // Registered 8x8 signed multipliers beside each sequencer
    always @(posedge cclk) bus_a.mul_z <= 16'(bus_a.mul_x) * 16'(bus_a.mul_y);
    always @(posedge cclk) bus_b.mul_z <= 16'(bus_b.mul_x) * 16'(bus_b.mul_y);

    int cyc = 0;
    always @(posedge cclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_acc = 0;

    typedef struct {
        longint acc;
        bit     sat;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake
    always @(negedge cclk) begin
        exp_t e;
        if (bus_a.out_valid && out_ready) begin
            if (q_a.size() == 0) check("a_unexpected_result", 1, q_a.size());
            else begin
                e = q_a.pop_front();
                check("a_out_acc", longint'(bus_a.out_acc), e.acc);
                check("a_out_sat", longint'(bus_a.out_sat), longint'(e.sat));
                $display("result acc24 acc=%0d sat=%0d", bus_a.out_acc, bus_a.out_sat);
            end
        end
        if (bus_b.out_valid && out_ready) begin
            if (q_b.size() == 0) check("b_unexpected_result", 1, q_b.size());
            else begin
                e = q_b.pop_front();
                check("b_out_acc", longint'(bus_b.out_acc), e.acc);
                check("b_out_sat", longint'(bus_b.out_sat), longint'(e.sat));
                $display("result acc16 acc=%0d sat=%0d", bus_b.out_acc, bus_b.out_sat);
            end
        end
    end

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic push_exp(input longint a24, input bit s24, input longint a16, input bit s16);
        exp_t e;
        e.acc = a24; e.sat = s24; q_a.push_back(e);
        e.acc = a16; e.sat = s16; q_b.push_back(e);
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input int x, input int y);
        bit was;
        bit done = 1'b0;
        in_x     = 8'(x);
        in_y     = 8'(y);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            was = bus_a.in_ready;
            tick();
            if (was) done = 1'b1;
        end
        in_valid = 1'b0;
        check("pair_accepted", longint'(done), 1);
        last_acc = cyc;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("in_ready_gap", longint'(bus_a.in_ready), 1);
        end
    endtask

    task automatic wait_result(input string name);
        bit seen = 1'b0;
        int k = last_acc;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = bus_a.out_valid;
        end
        check({name, "_valid"}, longint'(seen), 1);
        check({name, "_latency"}, longint'(cyc - k), 2);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_consume", longint'(bus_a.busy), 0);
    endtask

    initial begin
        logic signed [23:0] held;
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
        held = '0;
    end

    initial begin
        logic signed [23:0] hold_acc;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", longint'(bus_a.busy), 0);
        check("rst_in_ready", longint'(bus_a.in_ready), 0);
        check("rst_out_valid", longint'(bus_a.out_valid), 0);
        check("rst_out_acc", longint'(bus_a.out_acc), 0);
        check("rst_mul_x", longint'(bus_a.mul_x), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic job, back-to-back
        push_exp(16111, 0, 16111, 0);
        start_job(3);
        send_pair(3, 4); send_pair(-5, 6); send_pair(127, 127);
        wait_result("basic");
        consume();

        // Same pairs with 2-cycle gaps
        push_exp(16111, 0, 16111, 0);
        start_job(3);
        send_pair(3, 4); gap(2); send_pair(-5, 6); gap(2); send_pair(127, 127);
        wait_result("gapped");
        consume();

        // Positive saturation: 16-bit clamps at 32767 then adds -1
        push_exp(32767, 0, 32766, 1);
        start_job(3);
        send_pair(-128, -128); send_pair(-128, -128); send_pair(-1, 1);
        wait_result("sat_pos");
        consume();

        // Negative saturation
        push_exp(-48768, 0, -32768, 1);
        start_job(3);
        send_pair(-128, 127); send_pair(-128, 127); send_pair(-128, 127);
        wait_result("sat_neg");
        consume();

        // Empty job
        push_exp(0, 0, 0, 0);
        start_job(0);
        check("empty_valid_next_cycle", longint'(bus_a.out_valid), 1);
        consume();

        // start pulsed during FEED must not disturb the job
        push_exp(-18, 0, -18, 0);
        start_job(2);
        start = 1'b1; len = LEN_W'(7);
        send_pair(3, 4);
        start = 1'b0;
        send_pair(-5, 6);
        wait_result("ignored_start");
        consume();

        // Result backpressure
        push_exp(12, 0, 12, 0);
        start_job(1);
        send_pair(3, 4);
        wait_result("backpressure");
        hold_acc = bus_a.out_acc;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_held", longint'(bus_a.out_valid), 1);
            check("bp_acc_held", longint'(bus_a.out_acc), longint'(hold_acc));
        end
        consume();

        // Asynchronous reset one cycle after the second accept
        start_job(3);
        send_pair(10, 10); send_pair(20, 20);
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", longint'(bus_a.busy), 0);
        check("midrst_in_ready", longint'(bus_a.in_ready), 0);
        check("midrst_out_valid", longint'(bus_a.out_valid), 0);
        check("midrst_out_acc", longint'(bus_a.out_acc), 0);
        check("midrst_out_sat", longint'(bus_a.out_sat), 0);
        check("midrst_mul_x", longint'(bus_a.mul_x), 0);
        check("midrst_mul_y", longint'(bus_a.mul_y), 0);
        tick();
        rst = 1'b0;
        tick();

        push_exp(-6, 0, -6, 0);
        start_job(1);
        send_pair(-2, 3);
        wait_result("post_reset");
        consume();

        tick(); tick();
        check("scoreboard_empty_a", longint'(q_a.size()), 0);
        check("scoreboard_empty_b", longint'(q_b.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
